uart_rx_responder: RTL

UART_RX_RESPONDER -- requirements
Module: uart_rx_responder

---
 rtl/uart_rx_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_responder.sv
// UART 8N1 receiver with a single-byte holding register and a CPU handshake.
// A received byte is held in uart_read_byte with int0 raised until the CPU
// pulses uart_read_end. A byte that completes while one is still unread is
// dropped and flagged through the sticky overrun bit. A low stop bit produces
// a one-cycle frame_err pulse. Reception never waits on the CPU.
module uart_rx_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       uart_read_end,
  output logic [7:0] uart_read_byte,
  output logic       int0,
  output logic       overrun,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Mid-bit point of the start bit and the last count of a full bit period.
  localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta_q;
  logic        rx_s_q;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;

  // Combinational outcome of the stop-bit sample in the current cycle.
  logic        stop_ok_s;
  logic        stop_bad_s;

  logic [7:0]  byte_q, byte_d;
  logic        int0_q, int0_d;
  logic        ovr_q, ovr_d;
  logic        fe_q, fe_d;

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: find start bit, sample its middle, then sample each
  // following bit one full period later (i.e. in the middle of that bit).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    stop_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s_q == 1'b0) begin
          state_d = START;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = 16'd0;
          if (rx_s_q == 1'b0) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            // Start bit vanished before its midpoint: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          if (rx_s_q == 1'b1) begin
            stop_ok_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Delivery to the holding register and CPU handshake / status flags.
  always_comb begin
    byte_d = byte_q;
    int0_d = int0_q;
    ovr_d  = ovr_q;
    fe_d   = stop_bad_s;
    if (stop_ok_s) begin
      if (!int0_q) begin
        byte_d = shift_q;
        int0_d = 1'b1;
      end else if (uart_read_end) begin
        // Old byte consumed in the same cycle: replace it, stay pending.
        byte_d = shift_q;
        int0_d = 1'b1;
        ovr_d  = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (uart_read_end && int0_q) begin
      int0_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      int0_d = int0_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= 8'h00;
      int0_q <= 1'b0;
      ovr_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      byte_q <= byte_d;
      int0_q <= int0_d;
      ovr_q  <= ovr_d;
      fe_q   <= fe_d;
    end
  end

  assign uart_read_byte = byte_q;
  assign int0           = int0_q;
  assign overrun        = ovr_q;
  assign frame_err      = fe_q;

endmodule
